// File: rtl/decrypter_pkg.sv
// Shared crypto package: FSM state encodings and default width constants used
// by the decrypter (and the matching encrypter).
package decrypter_pkg;

  localparam int unsigned DEC_DATA_WIDTH  = 32;
  localparam int unsigned DEC_KEY_WIDTH   = 32;
  localparam int unsigned DEC_ROT_WIDTH   = 5;
  localparam int unsigned DEC_STATE_WIDTH = 3;

  // Codes 4-7 are unused; the FSM decodes them as ST_IDLE.
  typedef enum logic [DEC_STATE_WIDTH-1:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_DATA = 3'd1,
    ST_DECRYPT   = 3'd2,
    ST_SEND      = 3'd3
  } dec_state_e;

endpackage

// File: rtl/key_rotator.sv
// Combinational key rotate-left by offset, modulo WIDTH.
// Ports:
//   key     - key word to rotate
//   offset  - rotate-left amount (0 .. WIDTH-1)
//   rotated - key rotated left by offset
module key_rotator #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ROT_WIDTH = 5
) (
  input  logic [WIDTH-1:0]     key,
  input  logic [ROT_WIDTH-1:0] offset,
  output logic [WIDTH-1:0]     rotated
);

  logic [2*WIDTH-1:0] doubled;

  // Shifting the doubled key keeps offset 0 a plain pass-through of the upper half.
  always_comb begin
    doubled = {key, key} << offset;
    rotated = doubled[2*WIDTH-1:WIDTH];
  end

endmodule

// File: rtl/decrypter.sv
// Decrypter: loads a key word, then accepts ciphertext words and returns
// plaintext = ciphertext XOR rotl(key, rot_offset) through a req/ack handshake.
// Optional feature macro: DECRYPTER_CHECKSUM_EN adds a `checksum` output that
// XOR-accumulates every delivered plaintext and clears on key load.
// Ports:
//   clk        - clock, rising edge
//   reset      - asynchronous active-low reset
//   dataIn     - key word when prog sampled, ciphertext when rdyIn accepted
//   rot_offset - key rotate-left amount captured with the ciphertext
//   prog       - key-load request (level-sampled)
//   rdyIn      - ciphertext valid
//   ackOut     - consumer accepted dataOut
//   dataOut    - registered plaintext
//   reqIn      - ready for ciphertext
//   reqOut     - dataOut valid
//   state      - current FSM state (debug)
//   checksum   - plaintext XOR accumulator (DECRYPTER_CHECKSUM_EN only)
module decrypter
  import decrypter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEC_DATA_WIDTH,
  parameter int unsigned KEY_WIDTH  = DEC_KEY_WIDTH,
  parameter int unsigned ROT_WIDTH  = DEC_ROT_WIDTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      dataIn,
  input  logic [ROT_WIDTH-1:0]       rot_offset,
  input  logic                       prog,
  input  logic                       rdyIn,
  input  logic                       ackOut,
  output logic [DATA_WIDTH-1:0]      dataOut,
  output logic                       reqIn,
  output logic                       reqOut,
  output logic [DEC_STATE_WIDTH-1:0] state
`ifdef DECRYPTER_CHECKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0]      checksum
`endif
);

  logic [KEY_WIDTH-1:0]       key_q;
  logic [DATA_WIDTH-1:0]      cipher_q;
  logic [ROT_WIDTH-1:0]       offset_q;
  logic [KEY_WIDTH-1:0]       rot_key;

  logic [DEC_STATE_WIDTH-1:0] state_nxt;
  logic [KEY_WIDTH-1:0]       key_nxt;
  logic [DATA_WIDTH-1:0]      cipher_nxt;
  logic [ROT_WIDTH-1:0]       offset_nxt;
  logic [DATA_WIDTH-1:0]      data_nxt;
  logic                       req_in_nxt;
  logic                       req_out_nxt;
`ifdef DECRYPTER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0]      checksum_nxt;
`endif

  key_rotator #(
    .WIDTH     (KEY_WIDTH),
    .ROT_WIDTH (ROT_WIDTH)
  ) u_key_rotator (
    .key     (key_q),
    .offset  (offset_q),
    .rotated (rot_key)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      key_q    <= '0;
      cipher_q <= '0;
      offset_q <= '0;
      dataOut  <= '0;
      reqIn    <= 1'b0;
      reqOut   <= 1'b0;
`ifdef DECRYPTER_CHECKSUM_EN
      checksum <= '0;
`endif
    end else begin
      state    <= state_nxt;
      key_q    <= key_nxt;
      cipher_q <= cipher_nxt;
      offset_q <= offset_nxt;
      dataOut  <= data_nxt;
      reqIn    <= req_in_nxt;
      reqOut   <= req_out_nxt;
`ifdef DECRYPTER_CHECKSUM_EN
      checksum <= checksum_nxt;
`endif
    end
  end

  // Next-state and next-register logic; unused codes fall into the IDLE branch.
  always_comb begin
    state_nxt   = state;
    key_nxt     = key_q;
    cipher_nxt  = cipher_q;
    offset_nxt  = offset_q;
    data_nxt    = dataOut;
    req_in_nxt  = reqIn;
    req_out_nxt = reqOut;
`ifdef DECRYPTER_CHECKSUM_EN
    checksum_nxt = checksum;
`endif

    case (state)
      ST_WAIT_DATA: begin
        // A key load wins over a pending ciphertext, which stays unconsumed.
        if (prog) begin
          key_nxt    = dataIn[KEY_WIDTH-1:0];
          req_in_nxt = 1'b1;
`ifdef DECRYPTER_CHECKSUM_EN
          checksum_nxt = '0;
`endif
        end else if (reqIn && rdyIn) begin
          cipher_nxt = dataIn;
          offset_nxt = rot_offset;
          req_in_nxt = 1'b0;
          state_nxt  = ST_DECRYPT;
        end
      end

      ST_DECRYPT: begin
        data_nxt    = cipher_q ^ rot_key;
        req_out_nxt = 1'b1;
        state_nxt   = ST_SEND;
      end

      ST_SEND: begin
        if (ackOut) begin
          req_out_nxt = 1'b0;
          req_in_nxt  = 1'b1;
          state_nxt   = ST_WAIT_DATA;
`ifdef DECRYPTER_CHECKSUM_EN
          checksum_nxt = checksum ^ dataOut;
`endif
        end
      end

      default: begin
        // IDLE: no key yet, so rdyIn is ignored.
        if (prog) begin
          key_nxt    = dataIn[KEY_WIDTH-1:0];
          req_in_nxt = 1'b1;
          state_nxt  = ST_WAIT_DATA;
`ifdef DECRYPTER_CHECKSUM_EN
          checksum_nxt = '0;
`endif
        end
      end
    endcase
  end

endmodule

// File: doc/decrypter.md
DECRYPTER -- requirements
Module: decrypter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, ciphertext/plaintext word width.
REQ-002 SHALL have parameter KEY_WIDTH, default 32, key width; equals DATA_WIDTH.
REQ-003 SHALL have parameter ROT_WIDTH, default 5, rotation-offset width; 2**ROT_WIDTH == KEY_WIDTH.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port dataIn  input  DATA_WIDTH  key word when prog sampled, ciphertext when rdyIn accepted.
REQ-007 SHALL have port rot_offset  input  ROT_WIDTH  key rotate-left amount, captured with ciphertext.
REQ-008 SHALL have port prog  input  1  key-load request, level-sampled.
REQ-009 SHALL have port rdyIn  input  1  ciphertext valid.
REQ-010 SHALL have port ackOut  input  1  consumer accepted dataOut.
REQ-011 SHALL have port dataOut  output  DATA_WIDTH  registered plaintext.
REQ-012 SHALL have port reqIn  output  1  decrypter ready for ciphertext.
REQ-013 SHALL have port reqOut  output  1  dataOut valid.
REQ-014 SHALL have port state  output  3  current FSM state, debug.

Function
REQ-015 SHALL implement states IDLE=0, WAIT_DATA=1, DECRYPT=2, SEND=3; codes 4-7 unused, decoded as IDLE.
REQ-016 SHALL, in IDLE or WAIT_DATA with prog=1, load key <= dataIn[KEY_WIDTH-1:0], go to WAIT_DATA, set reqIn=1.
REQ-017 SHALL ignore rdyIn in IDLE (no key programmed).
REQ-018 SHALL, in WAIT_DATA with prog=0, reqIn=1 and rdyIn=1, capture dataIn and rot_offset, clear reqIn, go to DECRYPT.
REQ-019 SHALL give prog priority over rdyIn when both are high in WAIT_DATA; the ciphertext is not consumed.
REQ-020 SHALL, in DECRYPT, register dataOut = ciphertext XOR rotl(key, offset), set reqOut=1, go to SEND.
REQ-021 SHALL compute rotl modulo KEY_WIDTH; offset 0 yields key unchanged (no shift by KEY_WIDTH).
REQ-022 SHALL hold dataOut and reqOut stable in SEND until ackOut=1 is sampled, then clear reqOut, set reqIn=1, go to WAIT_DATA.
REQ-023 SHALL ignore prog and rdyIn in DECRYPT and SEND.
REQ-024 SHALL have latency: rdyIn accepted at edge N -> reqOut high after edge N+1; minimum 3 cycles per word with ackOut tied high.
REQ-025 SHALL retain the programmed key across words until reprogrammed or reset.

Reset
REQ-026 SHALL, on reset=0, asynchronously force state=IDLE, dataOut=0, reqIn=0, reqOut=0, key=0, captured ciphertext=0, captured offset=0, regardless of current state.
REQ-027 SHALL discard any in-flight word on reset; the first edge after reset release evaluates IDLE rules.

Configuration
REQ-028 SHALL, with DECRYPTER_CHECKSUM_EN defined, add output checksum (DATA_WIDTH): reset 0, XOR-accumulates each plaintext at the SEND->WAIT_DATA transition, cleared on key load.
REQ-029 SHALL, without DECRYPTER_CHECKSUM_EN, omit the checksum port and logic entirely; all other behaviour identical.

Structure
REQ-030 SHALL take state encodings and default width constants from the shared crypto package/constants header used by the encrypter.
REQ-031 SHALL instantiate one combinational sub-module key_rotator (key, offset -> rotated key), shared with the encrypter.

Verification
REQ-032 SHALL test basic decrypt: key 0x000000FF, offset 4, ciphertext 0x12345988 -> dataOut 0x12345678, reqOut after 2 edges.
REQ-033 SHALL test offset 0 and wrap: key 0xA5A5A5A5, offset 0, ciphertext 0xFFFFFFFF -> 0x5A5A5A5A; key 0x80000001, offset 1, ciphertext 0x00000003 -> 0x00000000.
REQ-034 SHALL test backpressure: ackOut low 5 cycles in SEND -> dataOut, reqOut=1, reqIn=0 stable; ackOut high -> WAIT_DATA, reqIn=1 next edge.
REQ-035 SHALL test prog and rdyIn together in WAIT_DATA -> key reloaded, no word decrypted, reqIn stays 1; rdyIn in IDLE -> no output.
REQ-036 SHALL test reset asserted mid-DECRYPT -> all outputs 0 and state=IDLE immediately, without a clock edge.
REQ-037 SHALL test, with DECRYPTER_CHECKSUM_EN, plaintexts 0x0F0F0F0F then 0xF0F0F0F0 -> checksum 0xFFFFFFFF; key reload -> 0.
